// File: rtl/cpu_test_loader.sv
// cpu_test_loader: host-side initiator for the CPU test/debug port.
//
// A session loads a program word stream into CPU memory through the test
// write path, releases test mode, pulses start, and watches the CPU state
// until halt or timeout. It then reads back a memory window through the test
// read path and streams it out with backpressure.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_data/in_last/in_ready  program word stream (input)
//   ext_addr/ext_data/test/tMemWrite/TestMem/start  CPU test port drive
//   cpu_state/cpu_outr/TestMemout   CPU observation and test read data
//   out_valid/out_data/out_ready    dump word stream (output)
//   result/done/timeout/overflow    session status (flags are sticky)
//
// Every output is a register. A new session clears the sticky flags.

module cpu_test_loader #(
  parameter logic [15:0] LOAD_BASE   = 16'h0000,
  parameter int unsigned MAX_WORDS   = 256,
  parameter logic [4:0]  HALT_STATE  = 5'd31,
  parameter logic [15:0] RUN_TIMEOUT = 16'hFFFF,
  parameter logic [15:0] DUMP_BASE   = 16'h0080,
  parameter int unsigned DUMP_LEN    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] ext_addr,
  output logic [15:0] ext_data,
  output logic        test,
  output logic        tMemWrite,
  output logic        TestMem,
  output logic        start,
  input  logic [4:0]  cpu_state,
  input  logic [15:0] cpu_outr,
  input  logic [15:0] TestMemout,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        done,
  output logic        timeout,
  output logic        overflow
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StRun,
    StDumpRd,
    StDumpOut
  } state_e;

  state_e      state_q, state_d;
  // Sub-step within StStart (release test / pulse start) and StDumpRd
  // (address cycle / data cycle).
  logic        phase_q, phase_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [15:0] cyc_q, cyc_d;
  logic        halt_seen_q, halt_seen_d;
  logic [15:0] dcnt_q, dcnt_d;

  logic        in_ready_q, in_ready_d;
  logic [15:0] ext_addr_q, ext_addr_d;
  logic [15:0] ext_data_q, ext_data_d;
  logic        test_q, test_d;
  logic        tmem_write_q, tmem_write_d;
  logic        testmem_q, testmem_d;
  logic        start_q, start_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic [15:0] result_q, result_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        overflow_q, overflow_d;

  logic        accept;
  logic [15:0] load_idx;
  logic        load_final;
  logic        halt_now;
  logic        run_expired;
  logic        dump_more;

  assign accept      = in_valid & in_ready_q;
  // The word accepted in IDLE is always index 0 of a fresh program.
  assign load_idx    = (state_q == StIdle) ? 16'd0 : wcnt_q;
  assign load_final  = in_last | (32'(load_idx) == MAX_WORDS - 1);
  // Halt needs the halt code on two consecutive RUN cycles.
  assign halt_now    = (cpu_state == HALT_STATE) && halt_seen_q;
  assign run_expired = (cyc_q == RUN_TIMEOUT - 16'd1);
  assign dump_more   = (32'(dcnt_q) + 32'd1) < DUMP_LEN;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    wcnt_d       = wcnt_q;
    cyc_d        = cyc_q;
    halt_seen_d  = halt_seen_q;
    dcnt_d       = dcnt_q;
    in_ready_d   = in_ready_q;
    ext_addr_d   = ext_addr_q;
    ext_data_d   = ext_data_q;
    test_d       = test_q;
    tmem_write_d = 1'b0;
    testmem_d    = testmem_q;
    start_d      = 1'b0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    result_d     = result_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    overflow_d   = overflow_q;

    unique case (state_q)
      StIdle, StLoad: begin
        if (state_q == StIdle) begin
          in_ready_d = 1'b1;
          test_d     = 1'b0;
          testmem_d  = 1'b0;
        end
        if (accept) begin
          if (state_q == StIdle) begin
            done_d     = 1'b0;
            timeout_d  = 1'b0;
            overflow_d = 1'b0;
          end
          test_d       = 1'b1;
          tmem_write_d = 1'b1;
          ext_addr_d   = LOAD_BASE + load_idx;
          ext_data_d   = in_data;
          wcnt_d       = load_idx + 16'd1;
          state_d      = StLoad;
          if (load_final) begin
            in_ready_d = 1'b0;
            state_d    = StStart;
            phase_d    = 1'b0;
            if (!in_last) begin
              overflow_d = 1'b1;
            end
          end
        end
      end

      StStart: begin
        if (!phase_q) begin
          test_d  = 1'b0;
          phase_d = 1'b1;
        end else begin
          // RUN begins in the cycle the start pulse is visible.
          start_d     = 1'b1;
          state_d     = StRun;
          cyc_d       = 16'd0;
          halt_seen_d = 1'b0;
        end
      end

      StRun: begin
        cyc_d       = cyc_q + 16'd1;
        halt_seen_d = (cpu_state == HALT_STATE);
        if (halt_now || run_expired) begin
          // Halt takes priority over a simultaneous timeout.
          timeout_d  = ~halt_now;
          result_d   = cpu_outr;
          state_d    = StDumpRd;
          phase_d    = 1'b0;
          dcnt_d     = 16'd0;
          test_d     = 1'b1;
          testmem_d  = 1'b1;
          ext_addr_d = DUMP_BASE;
        end
      end

      StDumpRd: begin
        // Read data arrives one cycle after the address is presented.
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          out_data_d  = TestMemout;
          out_valid_d = 1'b1;
          state_d     = StDumpOut;
        end
      end

      StDumpOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (dump_more) begin
            dcnt_d     = dcnt_q + 16'd1;
            ext_addr_d = DUMP_BASE + dcnt_q + 16'd1;
            state_d    = StDumpRd;
            phase_d    = 1'b0;
          end else begin
            test_d    = 1'b0;
            testmem_d = 1'b0;
            done_d    = 1'b1;
            state_d   = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      phase_q      <= 1'b0;
      wcnt_q       <= '0;
      cyc_q        <= '0;
      halt_seen_q  <= 1'b0;
      dcnt_q       <= '0;
      in_ready_q   <= 1'b0;
      ext_addr_q   <= '0;
      ext_data_q   <= '0;
      test_q       <= 1'b0;
      tmem_write_q <= 1'b0;
      testmem_q    <= 1'b0;
      start_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      result_q     <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      wcnt_q       <= wcnt_d;
      cyc_q        <= cyc_d;
      halt_seen_q  <= halt_seen_d;
      dcnt_q       <= dcnt_d;
      in_ready_q   <= in_ready_d;
      ext_addr_q   <= ext_addr_d;
      ext_data_q   <= ext_data_d;
      test_q       <= test_d;
      tmem_write_q <= tmem_write_d;
      testmem_q    <= testmem_d;
      start_q      <= start_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      result_q     <= result_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      overflow_q   <= overflow_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign ext_addr  = ext_addr_q;
  assign ext_data  = ext_data_q;
  assign test      = test_q;
  assign tMemWrite = tmem_write_q;
  assign TestMem   = testmem_q;
  assign start     = start_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign result    = result_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cpu_test_loader.sv
// Bench for cpu_test_loader: stub CPU with a registered test read path,
// scoreboards for test-port writes and dump words.
module tb_cpu_test_loader;

  localparam logic [15:0] LOAD_BASE   = 16'h0000;
  localparam int unsigned MAX_WORDS   = 4;
  localparam logic [4:0]  HALT_STATE  = 5'd31;
  localparam logic [15:0] RUN_TIMEOUT = 16'd20;
  localparam logic [15:0] DUMP_BASE   = 16'h0080;
  localparam int unsigned DUMP_LEN    = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, in_ready;
  logic [15:0] in_data;
  logic [15:0] ext_addr, ext_data;
  logic        test, tMemWrite, TestMem, start;
  logic [4:0]  cpu_state;
  logic [15:0] cpu_outr;
  logic [15:0] TestMemout;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [15:0] result;
  logic        done, timeout, overflow;

  cpu_test_loader #(
    .LOAD_BASE  (LOAD_BASE),
    .MAX_WORDS  (MAX_WORDS),
    .HALT_STATE (HALT_STATE),
    .RUN_TIMEOUT(RUN_TIMEOUT),
    .DUMP_BASE  (DUMP_BASE),
    .DUMP_LEN   (DUMP_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .ext_addr  (ext_addr),
    .ext_data  (ext_data),
    .test      (test),
    .tMemWrite (tMemWrite),
    .TestMem   (TestMem),
    .start     (start),
    .cpu_state (cpu_state),
    .cpu_outr  (cpu_outr),
    .TestMemout(TestMemout),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .result    (result),
    .done      (done),
    .timeout   (timeout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] dump_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Stub CPU memory read: data follows the registered address by one cycle.
  always @(posedge clk) begin
    if (TestMem) TestMemout <= dump_word(ext_addr);
  end

  logic [31:0] exp_wr[$];
  logic [31:0] exp_dump[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor.
  int last_wr_cyc = -10;
  int wr_run = 0;
  always @(negedge clk) begin
    if (rst_n && tMemWrite) begin
      check_eq("wr_no_testmem", 32'(TestMem), 32'd0);
      check_eq("wr_test_high", 32'(test), 32'd1);
      check_eq("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) check_eq("wr_addr_data", {ext_addr, ext_data}, exp_wr.pop_front());
      wr_run <= (last_wr_cyc == cyc - 1) ? wr_run + 1 : 1;
      last_wr_cyc <= cyc;
    end
  end

  // Start / timeout monitor.
  logic prev_start = 1'b0;
  logic prev_timeout = 1'b0;
  int   start_cyc = 0;
  int   timeout_cyc = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (start) begin
        check_eq("start_test_low", 32'(test), 32'd0);
        start_cyc <= cyc;
      end
      if (prev_start) check_eq("start_one_cycle", 32'(start), 32'd0);
      if (timeout && !prev_timeout) timeout_cyc <= cyc;
    end
    prev_start   <= start;
    prev_timeout <= timeout;
  end

  // Dump monitor: scoreboard plus hold-under-backpressure check.
  logic        hold_pending = 1'b0;
  logic [15:0] hold_data = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pending) begin
        check_eq("hold_valid", 32'(out_valid), 32'd1);
        check_eq("hold_data", 32'(out_data), 32'(hold_data));
      end
      if (out_valid && out_ready) begin
        check_eq("dump_expected", 32'(exp_dump.size() != 0), 32'd1);
        if (exp_dump.size() != 0)
          check_eq("dump_addr_data", {ext_addr, out_data}, exp_dump.pop_front());
        hold_pending <= 1'b0;
      end else begin
        hold_pending <= out_valid;
        hold_data    <= out_data;
      end
    end else begin
      hold_pending <= 1'b0;
    end
  end

  // Offers n words (data = seed*(k+1)); every accept is expected to write.
  task automatic send_prog(input int n, input bit use_last, input logic [15:0] seed,
                           output int acc);
    int budget;
    bit fin;
    acc = 0;
    budget = 0;
    while (acc < n && budget < n + 10) begin
      in_valid = 1'b1;
      in_data  = seed * 16'(acc + 1);
      in_last  = use_last && (acc == n - 1);
      if (in_ready) begin
        exp_wr.push_back({LOAD_BASE + 16'(acc), in_data});
        acc++;
        fin = in_last || (acc == int'(MAX_WORDS));
        tick();
        if (fin) check_eq("ready_drop", 32'(in_ready), 32'd0);
      end else begin
        tick();
      end
      budget++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain_dump(input int stall_idx, input int stall_len);
    int taken = 0;
    int stalls = 0;
    int budget = 0;
    for (int i = 0; i < int'(DUMP_LEN); i++)
      exp_dump.push_back({DUMP_BASE + 16'(i), dump_word(DUMP_BASE + 16'(i))});
    while (!done && budget < 400) begin
      if (out_valid && taken == stall_idx && stalls < stall_len) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
        if (out_valid) taken++;
      end
      tick();
      budget++;
    end
    out_ready = 1'b1;
    check_eq("done_set", 32'(done), 32'd1);
    check_eq("dump_count", 32'(exp_dump.size()), 32'd0);
  endtask

  int acc;
  int budget;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cpu_state = '0; cpu_outr = '0; out_ready = 1'b1;
    repeat (3) tick();
    check_eq("rst_flags", {23'd0, in_ready, test, tMemWrite, TestMem, start, out_valid,
                           done, timeout, overflow}, 32'd0);
    check_eq("rst_addr_data", {ext_addr, ext_data}, 32'd0);
    check_eq("rst_out_result", {out_data, result}, 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    check_eq("idle_ready", 32'(in_ready), 32'd1);

    // Session 1: 3-word program, CPU halts 10 cycles after start.
    cpu_outr = 16'hBEEF;
    send_prog(3, 1'b1, 16'h1111, acc);
    check_eq("s1_accepted", acc, 3);
    budget = 0;
    while (!start && budget < 20) begin tick(); budget++; end
    check_eq("s1_start_seen", 32'(start), 32'd1);
    repeat (10) tick();
    cpu_state = HALT_STATE;
    tick(); tick();
    cpu_state = 5'd0;
    drain_dump(-1, 0);
    check_eq("s1_writes_left", 32'(exp_wr.size()), 32'd0);
    check_eq("s1_wr_run", wr_run, 3);
    check_eq("s1_start_gap", start_cyc - last_wr_cyc, 2);
    check_eq("s1_result", 32'(result), 32'hBEEF);
    check_eq("s1_flags", {timeout, overflow}, 32'd0);

    // Session 2: CPU never halts; backpressure on dump word 2.
    cpu_outr = 16'h1234;
    send_prog(2, 1'b1, 16'h0A0A, acc);
    check_eq("s2_accepted", acc, 2);
    check_eq("s2_done_cleared", 32'(done), 32'd0);
    drain_dump(2, 5);
    check_eq("s2_timeout", 32'(timeout), 32'd1);
    check_eq("s2_timeout_cycles", timeout_cyc - start_cyc, int'(RUN_TIMEOUT));
    check_eq("s2_result", 32'(result), 32'h1234);
    check_eq("s2_overflow", 32'(overflow), 32'd0);

    // Session 3: 6 words without in_last, truncated at MAX_WORDS.
    cpu_outr = 16'h0F0F;
    send_prog(6, 1'b0, 16'h0301, acc);
    check_eq("s3_accepted", acc, int'(MAX_WORDS));
    drain_dump(-1, 0);
    check_eq("s3_writes_left", 32'(exp_wr.size()), 32'd0);
    check_eq("s3_overflow", 32'(overflow), 32'd1);
    check_eq("s3_timeout", 32'(timeout), 32'd1);
    check_eq("s3_result", 32'(result), 32'h0F0F);

    // Session 4: reset between the 2nd and 3rd write of a load.
    send_prog(2, 1'b0, 16'h5000, acc);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_load", {29'd0, test, tMemWrite, in_ready}, 32'd0);
    check_eq("rst_mid_writes", 32'(exp_wr.size()), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check_eq("post_rst_idle", {30'd0, in_ready, test}, 32'd2);
    send_prog(1, 1'b1, 16'h6000, acc);
    tick();
    check_eq("post_rst_write", 32'(exp_wr.size()), 32'd0);
    check_eq("post_rst_addr", 32'(ext_addr), 32'(LOAD_BASE));
    rst_n = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_test_loader.md
Name: cpu_test_loader

Overview:
Host-side initiator for the CPU's test/debug port. It accepts a program as a word stream and writes it into CPU memory through the external test write path. It then releases test mode, pulses start and watches the CPU state until halt or timeout. Finally it reads back a memory window through the test read path and streams it out, with backpressure.

Parameters:
LOAD_BASE, 16'h0000, first memory address written during load
MAX_WORDS, 256, maximum program length; the word at index MAX_WORDS-1 is forced last
HALT_STATE, 5'd31, CPU state code that means halted
RUN_TIMEOUT, 16'hFFFF, maximum RUN cycles before abort
DUMP_BASE, 16'h0080, first address read back
DUMP_LEN, 16, number of words read back (must be ≥1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  program word valid
in_data  in  16  program word
in_last  in  1  marks the final program word
in_ready  out  1  loader accepts in_data
ext_addr  out  16  CPU test address
ext_data  out  16  CPU test write data
test  out  1  CPU test-mode select
tMemWrite  out  1  CPU test memory write strobe
TestMem  out  1  CPU test memory read select
start  out  1  CPU start pulse
cpu_state  in  5  CPU controller state
cpu_outr  in  16  CPU output register
TestMemout  in  16  CPU test read data; valid the cycle after ext_addr is registered with TestMem=1
out_valid  out  1  dump word valid
out_data  out  16  dump word
out_ready  in  1  downstream accepts dump word
result  out  16  cpu_outr latched at halt or timeout
done  out  1  session complete (sticky)
timeout  out  1  RUN ended by timeout (sticky)
overflow  out  1  program truncated at MAX_WORDS (sticky)

Behaviour:
- All outputs are registered. Async reset drives every output to 0, clears all counters and sets the FSM to IDLE. Reset mid-session aborts it: test falls immediately, and no write strobe is left high.
- FSM states: IDLE, LOAD, START, RUN, DUMP_RD, DUMP_OUT.
- IDLE:
  - in_ready=1, test=0.
  - An accept (in_valid&&in_ready) clears done, timeout, overflow and the word count, then enters LOAD.
  - The accepted word is written like any other LOAD accept.
- LOAD:
  - in_ready=1.
  - Each accept at cycle N produces cycle N+1: test=1, tMemWrite=1, ext_addr=LOAD_BASE+index (16-bit wrap), ext_data=in_data.
  - tMemWrite is low in cycles with no accept. Back-to-back accepts give back-to-back writes.
  - If in_last is set, or the accepted word is index MAX_WORDS-1 without in_last, in_ready falls the next cycle and the FSM goes to START after the final write cycle.
  - The truncation case also sets overflow=1; later input is ignored until IDLE.
- START:
  - Cycle 1: test=0, tMemWrite=0.
  - Cycle 2: start=1 for exactly one cycle.
  - Then RUN, with the cycle counter cleared.
- RUN:
  - The counter increments each cycle.
  - Halt is cpu_state==HALT_STATE on two consecutive cycles. On halt, result<=cpu_outr and the FSM goes to DUMP_RD.
  - If the counter reaches RUN_TIMEOUT first: timeout=1, result<=cpu_outr, then DUMP_RD.
  - If halt and timeout occur in the same cycle, halt wins and timeout stays 0.
- DUMP_RD:
  - test=1, TestMem=1, ext_addr=DUMP_BASE+i (wrap).
  - Wait one cycle, capture TestMemout into out_data, set out_valid=1, go to DUMP_OUT.
- DUMP_OUT:
  - out_valid and out_data hold until out_ready.
  - On the handshake: out_valid falls and i increments.
  - If i < DUMP_LEN, the FSM goes to DUMP_RD.
  - Otherwise test=0, TestMem=0, done=1 and the FSM goes to IDLE.
- test is never 1 while start=1. tMemWrite and TestMem are never 1 together.

Test Plan:
- Load 3 words (1111, 2222, 3333, last on the third) with in_valid held continuously → tMemWrite high 3 consecutive cycles at ext_addr 0000/0001/0002 with matching ext_data; test falls; one-cycle start pulse two cycles after the last write.
- Stub CPU: cpu_state=31 for 2 cycles, 10 cycles after start, with cpu_outr=16'hBEEF → result=BEEF, timeout=0; DUMP_LEN=16 reads from 0080 to 008F with correct data order; done=1.
- Stub CPU never halts, RUN_TIMEOUT=20 → timeout=1 exactly 20 cycles into RUN; dump still runs; done=1.
- Dump with out_ready low for 5 cycles on word 2 → out_valid and out_data stable throughout; no address skipped or repeated.
- MAX_WORDS=4, send 6 words without in_last → 4 writes only, overflow=1, in_ready falls after the 4th accept.
- Assert rst_n low during LOAD between the 2nd and 3rd write → test, tMemWrite and in_ready go to 0 immediately; after release the FSM is IDLE and a new load starts again at LOAD_BASE.
